// File: rtl/expression_pipe_pkg.sv
// Shared op codes and helpers for the pipelined expression evaluator.
package expression_pipe_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_MULH = 3'd2;
    localparam logic [OP_W-1:0] OP_CMP  = 3'd3;
    localparam logic [OP_W-1:0] OP_SHR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNR  = 3'd5;
    localparam logic [OP_W-1:0] OP_ACC  = 3'd6;
    localparam logic [OP_W-1:0] OP_CLR  = 3'd7;

    // Signed only when both operands are signed; SHR looks at a alone.
    function automatic logic eff_signed(input logic [OP_W-1:0] op,
                                        input logic sgn_a,
                                        input logic sgn_b);
        return (op == OP_SHR) ? sgn_a : (sgn_a && sgn_b);
    endfunction

endpackage

// File: rtl/expression_lane.sv
// One lane: combinational expression evaluation plus its accumulator.
module expression_lane
    import expression_pipe_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            accept,
    input  logic [OP_W-1:0] op,
    input  logic            sgn_a,
    input  logic            sgn_b,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic [W-1:0]    result_c
);

    localparam int unsigned SH_W = $clog2(W);
    localparam int unsigned PW   = 2 * W;

    logic            s;
    logic [W-1:0]    acc;
    logic [W-1:0]    acc_sum;
    logic [PW-1:0]   a_ext;
    logic [PW-1:0]   b_ext;
    logic [PW-1:0]   prod;
    logic [SH_W-1:0] shamt;
    logic [W-1:0]    shr;
    logic            lt;
    logic            xnr;

    assign s = eff_signed(op, sgn_a, sgn_b);

    // Extending to 2W first makes the truncated product exact for both signednesses.
    assign a_ext   = {{W{s & a[W-1]}}, a};
    assign b_ext   = {{W{s & b[W-1]}}, b};
    assign prod    = a_ext * b_ext;
    assign lt      = s ? ($signed(a) < $signed(b)) : (a < b);
    assign shamt   = b[SH_W-1:0];
    assign shr     = sgn_a ? W'($signed(a) >>> shamt) : (a >> shamt);
    assign xnr     = ~^(a ^ b);
    assign acc_sum = acc + a;

    always_comb begin
        result_c = '0;
        case (op)
            OP_ADD:  result_c = a + b;
            OP_SUB:  result_c = a - b;
            OP_MULH: result_c = prod[PW-1:W];
            OP_CMP:  result_c = W'(lt);
            OP_SHR:  result_c = shr;
            OP_XNR:  result_c = W'(xnr);
            OP_ACC:  result_c = acc_sum;
            OP_CLR:  result_c = '0;
            default: result_c = '0;
        endcase
    end

    // Accumulator advances only when the transaction is actually accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (accept) begin
            if (op == OP_ACC) begin
                acc <= acc_sum;
            end else if (op == OP_CLR) begin
                acc <= '0;
            end
        end
    end

endmodule

// File: rtl/expression_pipe.sv
// LANES-wide expression evaluator behind a STAGES-deep stallable pipeline.
module expression_pipe
    import expression_pipe_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    op,
    input  logic               sgn_a,
    input  logic               sgn_b,
    input  logic [LANES*W-1:0] a,
    input  logic [LANES*W-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] y
);

    localparam int unsigned BW = LANES * W;

    logic              en;
    logic              accept;
    logic [BW-1:0]     lane_y;
    logic [STAGES-1:0] stage_valid;
    logic [BW-1:0]     stage_data [STAGES];

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        expression_lane #(.W(W)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .accept   (accept),
            .op       (op),
            .sgn_a    (sgn_a),
            .sgn_b    (sgn_b),
            .a        (a[i*W +: W]),
            .b        (b[i*W +: W]),
            .result_c (lane_y[i*W +: W])
        );
    end

    // Whole pipeline shifts together on en; bubbles are carried, not collapsed.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid <= '0;
            for (int s = 0; s < STAGES; s++) begin
                stage_data[s] <= '0;
            end
        end else if (en) begin
            stage_valid[0] <= in_valid;
            stage_data[0]  <= lane_y;
            for (int s = 1; s < STAGES; s++) begin
                stage_valid[s] <= stage_valid[s-1];
                stage_data[s]  <= stage_data[s-1];
            end
        end
    end

    assign out_valid = stage_valid[STAGES-1];
    assign y         = stage_data[STAGES-1];

endmodule

// File: tb/tb_expression_pipe.sv
// Self-checking bench: directed table, ACC/reset/backpressure sequences, random scoreboard.
module tb_expression_pipe;

    localparam int unsigned W      = 8;
    localparam int unsigned LANES  = 4;
    localparam int unsigned STAGES = 2;
    localparam int unsigned BW     = LANES * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic          sgn_a;
    logic          sgn_b;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] y;

    always #5 clk = ~clk;

    expression_pipe #(.W(W), .LANES(LANES), .STAGES(STAGES)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .sgn_a     (sgn_a),
        .sgn_b     (sgn_b),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    typedef struct {
        logic [BW-1:0] y;
        int            cyc;
    } exp_t;

    typedef struct {
        string      name;
        logic [2:0] op;
        bit         sa;
        bit         sb;
        logic [W-1:0] a0;
        logic [W-1:0] b0;
        logic [W-1:0] exp0;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t q[$];
    logic [BW-1:0] emit_log[$];
    int acc_m[LANES];
    bit emitted;
    bit last_acc;
    logic [BW-1:0] last_y;
    int last_lat;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int sx(input int v, input bit s);
        return (s && v >= (1 << (W-1))) ? v - (1 << W) : v;
    endfunction

    // Reference lane result from the op rules with plain integer arithmetic.
    function automatic int ref_lane(input int opc, input bit sa, input bit sb,
                                    input int av, input int bv,
                                    input int acc_in, output int acc_out);
        int m;
        bit s;
        int x;
        int z;
        int r;
        m = (1 << W) - 1;
        s = sa && sb;
        x = sx(av, s);
        z = sx(bv, s);
        r = 0;
        acc_out = acc_in;
        case (opc)
            0: r = av + bv;
            1: r = av - bv;
            2: r = (x * z) >>> W;
            3: r = (x < z) ? 1 : 0;
            4: r = sa ? (sx(av, 1'b1) >>> (bv % W)) : (av >> (bv % W));
            5: r = ($countones(av ^ bv) % 2 == 0) ? 1 : 0;
            6: begin acc_out = (acc_in + av) & m; r = acc_out; end
            default: begin acc_out = 0; r = 0; end
        endcase
        return r & m;
    endfunction

    // One clock: score emission, model acceptance, advance to next negedge.
    task automatic step();
        exp_t e;
        logic [BW-1:0] ey;
        int na;
        int r;
        #1;
        last_acc = 1'b0;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got y=%h with nothing outstanding (cycle %0d)", y, cyc);
            end else begin
                e = q.pop_front();
                chk("scoreboard", y, e.y);
                last_y   = y;
                last_lat = cyc - e.cyc;
                emitted  = 1'b1;
                emit_log.push_back(y);
            end
        end
        if (in_valid && in_ready) begin
            ey = '0;
            for (int l = 0; l < LANES; l++) begin
                r = ref_lane(int'(op), sgn_a, sgn_b, int'(a[l*W +: W]), int'(b[l*W +: W]),
                             acc_m[l], na);
                acc_m[l] = na;
                ey[l*W +: W] = W'(r);
            end
            e.y   = ey;
            e.cyc = cyc;
            q.push_back(e);
            last_acc = 1'b1;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cyc += 2;
        reset = 1'b0;
        q.delete();
        for (int l = 0; l < LANES; l++) acc_m[l] = 0;
    endtask

    task automatic send(input logic [2:0] o, input bit sa, input bit sb,
                        input logic [BW-1:0] av, input logic [BW-1:0] bv);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        op = o; sgn_a = sa; sgn_b = sb; a = av; b = bv;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d results still outstanding, expected 0", name, q.size());
            q.delete();
        end
    endtask

    vec_t tbl[10];
    logic [BW-1:0] ra;
    logic [BW-1:0] rb;
    logic [BW-1:0] held;
    int sent;
    int stall;

    initial begin
        tbl[0] = '{"mulh_ss", 3'd2, 1'b1, 1'b1, 8'hFD, 8'h05, 8'hFF};
        tbl[1] = '{"mulh_su", 3'd2, 1'b1, 1'b0, 8'hFD, 8'h05, 8'h04};
        tbl[2] = '{"cmp_ss",  3'd3, 1'b1, 1'b1, 8'hFF, 8'h01, 8'h01};
        tbl[3] = '{"cmp_su",  3'd3, 1'b1, 1'b0, 8'hFF, 8'h01, 8'h00};
        tbl[4] = '{"shr_ar",  3'd4, 1'b1, 1'b0, 8'h80, 8'h03, 8'hF0};
        tbl[5] = '{"shr_lg",  3'd4, 1'b0, 1'b1, 8'h80, 8'h03, 8'h10};
        tbl[6] = '{"add_wr",  3'd0, 1'b0, 1'b0, 8'hF0, 8'h20, 8'h10};
        tbl[7] = '{"sub_bw",  3'd1, 1'b1, 1'b1, 8'h05, 8'h07, 8'hFE};
        tbl[8] = '{"xnr_ev",  3'd5, 1'b0, 1'b0, 8'h03, 8'h00, 8'h01};
        tbl[9] = '{"xnr_od",  3'd5, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00};

        op = 3'd0; sgn_a = 1'b0; sgn_b = 1'b0; a = '0; b = '0;
        emitted = 1'b0; last_acc = 1'b0; last_y = '0; last_lat = 0;
        @(negedge clk);
        do_reset();

        chk("reset_y", y, '0);
        chk("reset_out_valid", BW'(out_valid), '0);
        chk("reset_in_ready", BW'(in_ready), BW'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("idle_out_valid", BW'(out_valid), '0);

        // Fresh accumulators: ACC with a=0 must read back zero in every lane.
        emitted = 1'b0;
        send(3'd6, 1'b0, 1'b0, '0, BW'($urandom));
        drain("acc0");
        chk("acc_after_reset", last_y, '0);

        for (int t = 0; t < 10; t++) begin
            ra = BW'($urandom);
            rb = BW'($urandom);
            ra[W-1:0] = tbl[t].a0;
            rb[W-1:0] = tbl[t].b0;
            emitted = 1'b0;
            send(tbl[t].op, tbl[t].sa, tbl[t].sb, ra, rb);
            drain(tbl[t].name);
            chk({tbl[t].name, "_lane0"}, BW'(last_y[W-1:0]), BW'(tbl[t].exp0));
            chk({tbl[t].name, "_latency"}, BW'(last_lat), BW'(STAGES));
        end

        // CLR then two back-to-back ACCs of 0x90 in every lane.
        send(3'd7, 1'b0, 1'b0, BW'($urandom), '0);
        drain("clr");
        emit_log.delete();
        in_valid = 1'b1; out_ready = 1'b1; op = 3'd6; a = {LANES{8'h90}}; b = '0;
        step();
        step();
        in_valid = 1'b0;
        drain("acc_pair");
        chk("acc_count", BW'(emit_log.size()), BW'(2));
        if (emit_log.size() == 2) begin
            chk("acc_first", emit_log[0], {LANES{8'h90}});
            chk("acc_wrap", emit_log[1], {LANES{8'h20}});
        end

        // Reset with an ACC in flight: it must vanish and the accumulator restart.
        send(3'd7, 1'b0, 1'b0, '0, '0);
        drain("clr2");
        send(3'd6, 1'b0, 1'b0, {LANES{8'h90}}, '0);
        do_reset();
        chk("reset_flush_valid", BW'(out_valid), '0);
        emit_log.delete();
        send(3'd6, 1'b0, 1'b0, {LANES{8'h90}}, '0);
        drain("acc_post_reset");
        chk("acc_post_reset", emit_log.size() > 0 ? emit_log[0] : '0, {LANES{8'h90}});

        // Five ADDs with a three-cycle stall once output appears.
        emit_log.delete();
        sent = 0;
        stall = 0;
        held = '0;
        for (int c = 0; c < 40 && emit_log.size() < 5; c++) begin
            in_valid = (sent < 5);
            op = 3'd0; sgn_a = 1'b0; sgn_b = 1'b0;
            a = BW'($urandom); b = BW'($urandom);
            out_ready = !(out_valid && stall < 3);
            #1;
            if (!out_ready) begin
                if (stall == 0) held = y;
                else chk("stall_y_stable", y, held);
                chk("stall_in_ready", BW'(in_ready), '0);
                chk("stall_out_valid", BW'(out_valid), BW'(1));
                stall++;
            end
            step();
            if (last_acc) sent++;
        end
        in_valid = 1'b0;
        drain("bp");
        chk("bp_stall_cycles", BW'(stall), BW'(3));
        chk("bp_count", BW'(emit_log.size()), BW'(5));

        // Random traffic with random backpressure against the model.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            op    = 3'($urandom_range(0, 7));
            sgn_a = 1'($urandom);
            sgn_b = 1'($urandom);
            a = BW'($urandom);
            b = BW'($urandom);
            step();
        end
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/expression_pipe.md
Name: expression_pipe

Overview:
- Parametrised, pipelined successor to the fixed-width combinational expression blocks.
- Evaluates a selectable mixed-signedness expression on LANES independent W-bit operand pairs; results are concatenated into one packed output bus.
- Adds per-lane accumulators, a valid/ready handshake and configurable pipeline depth.
- Sits as a regression/stress target between a stimulus source and a result checker.

Parameters:
- W, 8, operand and result width per lane (>=4).
- LANES, 4, number of parallel lanes.
- STAGES, 2, pipeline register stages (>=1); sets latency.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts the input this cycle.
- op  in  3  operation code, shared by all lanes.
- sgn_a  in  1  a operands are signed.
- sgn_b  in  1  b operands are signed.
- a  in  LANES*W  lane i operand at bits [i*W +: W].
- b  in  LANES*W  lane i operand at bits [i*W +: W].
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- y  out  LANES*W  lane i result at bits [i*W +: W].

Behaviour:
- Reset (synchronous, active-high): all stage valids, out_valid, y and every accumulator go to 0. Reset wins over any simultaneous transfer. A reset mid-pipeline discards all in-flight transactions.
- Signedness rule: an operation is signed only if both operands are signed (sgn_a && sgn_b). Otherwise both operands are treated as unsigned, zero-extended. Exception: SHR uses sgn_a alone.
- Ops, per lane; results are truncated to W unless stated:
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 MULH: high W bits of the 2W-bit product, under the signedness rule.
  - 3 CMP: {0..., a<b}, under the signedness rule.
  - 4 SHR: a shifted right by b[clog2(W)-1:0]; arithmetic if sgn_a, logical otherwise.
  - 5 XNR: {0..., ~^(a^b)}.
  - 6 ACC: acc <= acc+a (wraps mod 2^W); result is the new acc.
  - 7 CLR: acc <= 0; result is 0.
- Accumulators update only at acceptance (in_valid && in_ready). Back-to-back ACC transactions therefore see each other's results in acceptance order.
- Pipeline control:
  - Global enable en = !out_valid || out_ready; in_ready = en.
  - When en=1, every stage shifts forward one position. When en=0, every stage holds.
  - Bubbles are not collapsed.
- Latency: exactly STAGES cycles from acceptance to out_valid when out_ready is held high. Full throughput is 1 transaction per cycle.
- Output stability: y and out_valid hold while out_valid && !out_ready. y is don't-care while out_valid=0, but it is registered and not X after reset.
- Simultaneous accept and emit in the same cycle is legal and required for full throughput.

Decomposition:
- Package expression_pipe_pkg holds:
  - op code localparams (OP_ADD..OP_CLR);
  - the op width (3);
  - a function computing the effective-signed flag.
- Sub-module expression_lane: one lane's combinational evaluation plus its accumulator register. It is instantiated LANES times by a generate loop.
- The top level owns the handshake and the STAGES-deep valid/data shift registers.

Test Plan:
- Reset then idle, with the W=8, LANES=4, STAGES=2 defaults -> y=0, out_valid=0, in_ready=1. Accumulators read 0 on a subsequent ACC with a=0.
- MULH, lane0 a=0xFD b=0x05:
  - sgn_a=sgn_b=1 -> y lane0=0xFF, arriving 2 cycles after acceptance;
  - sgn_b=0 -> y lane0=0x04.
- CMP, a=0xFF b=0x01:
  - both signed -> 0x01;
  - sgn_b=0 -> 0x00.
- SHR, a=0x80 b=0x03:
  - sgn_a=1 -> 0xF0;
  - sgn_a=0 -> 0x10.
- ACC sequence:
  - CLR, then ACC a=0x90 twice back-to-back -> results 0x90 then 0x20 (wrap);
  - reset after the first ACC -> next ACC a=0x90 gives 0x90.
- Backpressure:
  - stream 5 ADD transactions; hold out_ready=0 for 3 cycles once out_valid rises -> in_ready=0 during the stall, y held stable, no loss or duplication;
  - all 5 results appear in order once out_ready returns to 1.
